mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer_pkg.sv | 57 +++++
 rtl/mc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mc_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer: FSM states, opcodes,
// ALUOp codes, next-PC selects and trap causes.
package mc_sequencer_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned ALUOP_W  = 3;
   localparam int unsigned PCSEL_W  = 2;
   localparam int unsigned CAUSE_W  = 2;
   localparam int unsigned INSTR_W  = 32;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_ITYPE = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b100;

   localparam logic [PCSEL_W-1:0] PC_SEL_SEQ  = 2'd0;
   localparam logic [PCSEL_W-1:0] PC_SEL_REL  = 2'd1;
   localparam logic [PCSEL_W-1:0] PC_SEL_JALR = 2'd2;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_WDT     = 2'd2;

   // True for every opcode the sequencer knows how to execute.
   function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
         default:                            is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky TRAP and retire counter.
// Optional memory-wait watchdog enabled by defining MC_WDT_EN.
module mc_sequencer
   import mc_sequencer_pkg::*;
#(
   parameter int unsigned WDT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [2:0]          funct3,
   input  logic                rd_zero,
   input  logic                alu_zero,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                ir_we,
   output logic                pc_we,
   output logic                reg_we,
   output logic                mem_to_reg,
   output logic                alu_src,
   output logic [PCSEL_W-1:0]  pc_sel,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [STATE_W-1:0]  state,
   output logic                trap,
   output logic [CAUSE_W-1:0]  trap_cause,
   output logic [INSTR_W-1:0]  instret
);

   state_t               state_q, state_d;
   logic [CAUSE_W-1:0]   cause_q, cause_d;
   logic [INSTR_W-1:0]   instret_q;
   logic                 retire_c;

`ifdef MC_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
   logic [WDT_W-1:0] wdt_cnt_q;
   logic             wait_c;

   // A memory request is outstanding and not yet acknowledged this cycle.
   assign wait_c = ((state_q == S_FETCH) && run && !imem_ready) ||
                   ((state_q == S_MEM) && !dmem_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         wdt_cnt_q <= '0;
      else if (wait_c) wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
      else             wdt_cnt_q <= '0;
   end
`else
   logic unused_wdt;
   assign unused_wdt = ^WDT_CYCLES;
`endif

   // State, trap cause and retire counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (retire_c) instret_q <= instret_q + 32'd1;
      end
   end

   // Next-state and control decode; everything is held low while rst is asserted.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      retire_c   = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      pc_sel     = PC_SEL_SEQ;
      alu_op     = ALU_ADD;
      trap       = 1'b0;

      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = run;
               if (run && imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_legal_op(opcode)) begin
                  state_d = S_EXEC;
               end else begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            end
            S_EXEC: begin
               state_d = S_WB;
               alu_src = 1'b1;
               case (opcode)
                  OP_R: begin
                     alu_op  = ALU_RTYPE;
                     alu_src = 1'b0;
                  end
                  OP_I:              alu_op = ALU_ITYPE;
                  OP_LUI:            alu_op = ALU_LUI;
                  OP_LOAD, OP_STORE: state_d = S_MEM;
                  OP_BRANCH: begin
                     alu_op   = ALU_SUB;
                     alu_src  = 1'b0;
                     pc_we    = 1'b1;
                     retire_c = 1'b1;
                     state_d  = S_FETCH;
                     if (((funct3 == F3_BEQ) && alu_zero) ||
                         ((funct3 == F3_BNE) && !alu_zero))
                        pc_sel = PC_SEL_REL;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (opcode == OP_STORE);
               if (dmem_ready) begin
                  if (opcode == OP_STORE) begin
                     pc_we    = 1'b1;
                     retire_c = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end
            S_WB: begin
               reg_we     = !rd_zero;
               mem_to_reg = (opcode == OP_LOAD);
               pc_we      = 1'b1;
               if (opcode == OP_JAL)       pc_sel = PC_SEL_REL;
               else if (opcode == OP_JALR) pc_sel = PC_SEL_JALR;
               retire_c   = 1'b1;
               state_d    = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_FETCH;
         endcase

`ifdef MC_WDT_EN
         // Watchdog expiry on the last permitted wait cycle overrides normal sequencing.
         if (wait_c && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1))) begin
            state_d = S_TRAP;
            cause_d = CAUSE_WDT;
         end
`endif
      end
   end

   assign state      = state_q;
   assign trap_cause = cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle vector table plus hand sequences for
// reset mid-request, illegal-opcode trap and the memory-wait watchdog.
module tb_mc_sequencer;

   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] LUI  = 7'b0110111;

   logic        clk, rst, run, rd_zero, alu_zero, imem_ready, dmem_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, mem_to_reg, alu_src, trap;
   logic [1:0]  pc_sel, trap_cause;
   logic [2:0]  alu_op, state;
   logic [31:0] instret;

   typedef struct packed {
      logic       run;
      logic [6:0] opc;
      logic [2:0] f3;
      logic       rdz;
      logic       az;
      logic       ir;
      logic       dr;
   } vin_t;

   typedef struct packed {
      logic [2:0]  st;
      logic        ireq, dreq, dwe, irwe, pcwe;
      logic [1:0]  pcsel;
      logic        regwe, m2r;
      logic [2:0]  aop;
      logic        asrc;
      logic        trp;
      logic [1:0]  cause;
      logic [31:0] ic;
   } vexp_t;

   typedef struct {
      vin_t  i;
      vexp_t e;
   } vec_t;

   vec_t vt[$];
   int   checks = 0;
   int   passed = 0;

   mc_sequencer #(.WDT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
      .rd_zero(rd_zero), .alu_zero(alu_zero), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
      .mem_to_reg(mem_to_reg), .alu_src(alu_src), .pc_sel(pc_sel),
      .alu_op(alu_op), .state(state), .trap(trap), .trap_cause(trap_cause),
      .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vin_t vi(input logic r, input logic [6:0] o, input logic [2:0] f,
                               input logic rz, input logic z, input logic ir, input logic dr);
      return '{run: r, opc: o, f3: f, rdz: rz, az: z, ir: ir, dr: dr};
   endfunction

   function automatic vexp_t ve(input logic [2:0] st, input logic ireq, input logic dreq,
                                input logic dwe, input logic irwe, input logic pcwe,
                                input logic [1:0] pcsel, input logic regwe, input logic m2r,
                                input logic [2:0] aop, input logic asrc, input logic [31:0] ic);
      return '{st: st, ireq: ireq, dreq: dreq, dwe: dwe, irwe: irwe, pcwe: pcwe,
               pcsel: pcsel, regwe: regwe, m2r: m2r, aop: aop, asrc: asrc,
               trp: 1'b0, cause: 2'd0, ic: ic};
   endfunction

   function automatic vexp_t fx(input logic [31:0] ic);
      return ve(3'd0, 1, 0, 0, 1, 0, 2'd0, 0, 0, 3'd0, 0, ic);
   endfunction

   function automatic vexp_t dx(input logic [31:0] ic);
      return ve(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, ic);
   endfunction

   function automatic vexp_t actual();
      return {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
              mem_to_reg, alu_op, alu_src, trap, trap_cause, instret};
   endfunction

   task automatic apply(input vin_t x);
      run = x.run; opcode = x.opc; funct3 = x.f3; rd_zero = x.rdz;
      alu_zero = x.az; imem_ready = x.ir; dmem_ready = x.dr;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push(input vin_t i, input vexp_t e);
      vec_t v;
      v.i = i;
      v.e = e;
      vt.push_back(v);
   endtask

   initial begin
      int n;
      int bad;

      // add x1: zero-wait R-type
      push(vi(1, ADD, 3'd0, 0, 0, 1, 1), fx(0));
      push(vi(1, ADD, 3'd0, 0, 0, 1, 1), dx(0));
      push(vi(1, ADD, 3'd0, 0, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'b010, 0, 0));
      push(vi(1, ADD, 3'd0, 0, 0, 1, 1), ve(3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 0, 3'd0, 0, 0));
      // lw with three wait cycles
      push(vi(1, LW, 3'd2, 0, 0, 1, 1), fx(1));
      push(vi(1, LW, 3'd2, 0, 0, 1, 1), dx(1));
      push(vi(1, LW, 3'd2, 0, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 1));
      for (int k = 0; k < 3; k++)
         push(vi(1, LW, 3'd2, 0, 0, 1, 0), ve(3'd3, 0, 1, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 1));
      push(vi(1, LW, 3'd2, 0, 0, 1, 1), ve(3'd3, 0, 1, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 1));
      push(vi(1, LW, 3'd2, 0, 0, 1, 1), ve(3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 1, 3'd0, 0, 1));
      // sw
      push(vi(1, SW, 3'd2, 0, 0, 1, 1), fx(2));
      push(vi(1, SW, 3'd2, 0, 0, 1, 1), dx(2));
      push(vi(1, SW, 3'd2, 0, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 2));
      push(vi(1, SW, 3'd2, 0, 0, 1, 1), ve(3'd3, 0, 1, 1, 0, 1, 2'd0, 0, 0, 3'd0, 0, 2));
      // beq taken
      push(vi(1, BR, 3'd0, 1, 1, 1, 1), fx(3));
      push(vi(1, BR, 3'd0, 1, 1, 1, 1), dx(3));
      push(vi(1, BR, 3'd0, 1, 1, 1, 1), ve(3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 0, 3'b001, 0, 3));
      // bne with zero flag: not taken
      push(vi(1, BR, 3'd1, 1, 1, 1, 1), fx(4));
      push(vi(1, BR, 3'd1, 1, 1, 1, 1), dx(4));
      push(vi(1, BR, 3'd1, 1, 1, 1, 1), ve(3'd2, 0, 0, 0, 0, 1, 2'd0, 0, 0, 3'b001, 0, 4));
      // jalr x0
      push(vi(1, JALR, 3'd0, 1, 0, 1, 1), fx(5));
      push(vi(1, JALR, 3'd0, 1, 0, 1, 1), dx(5));
      push(vi(1, JALR, 3'd0, 1, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 5));
      push(vi(1, JALR, 3'd0, 1, 0, 1, 1), ve(3'd4, 0, 0, 0, 0, 1, 2'd2, 0, 0, 3'd0, 0, 5));
      // jal
      push(vi(1, JAL, 3'd0, 0, 0, 1, 1), fx(6));
      push(vi(1, JAL, 3'd0, 0, 0, 1, 1), dx(6));
      push(vi(1, JAL, 3'd0, 0, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 6));
      push(vi(1, JAL, 3'd0, 0, 0, 1, 1), ve(3'd4, 0, 0, 0, 0, 1, 2'd1, 1, 0, 3'd0, 0, 6));
      // lui
      push(vi(1, LUI, 3'd0, 0, 0, 1, 1), fx(7));
      push(vi(1, LUI, 3'd0, 0, 0, 1, 1), dx(7));
      push(vi(1, LUI, 3'd0, 0, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'b100, 1, 7));
      push(vi(1, LUI, 3'd0, 0, 0, 1, 1), ve(3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 0, 3'd0, 0, 7));
      // beq not taken
      push(vi(1, BR, 3'd0, 1, 0, 1, 1), fx(8));
      push(vi(1, BR, 3'd0, 1, 0, 1, 1), dx(8));
      push(vi(1, BR, 3'd0, 1, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 1, 2'd0, 0, 0, 3'b001, 0, 8));
      // run low: no fetch even with ready high
      push(vi(0, ADDI, 3'd0, 0, 0, 1, 1), ve(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 9));
      push(vi(0, ADDI, 3'd0, 0, 0, 1, 1), ve(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 9));
      // addi with one fetch wait cycle
      push(vi(1, ADDI, 3'd0, 0, 0, 0, 1), ve(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 9));
      push(vi(1, ADDI, 3'd0, 0, 0, 1, 1), fx(9));
      push(vi(1, ADDI, 3'd0, 0, 0, 1, 1), dx(9));
      push(vi(1, ADDI, 3'd0, 0, 0, 1, 1), ve(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'b011, 1, 9));
      push(vi(1, ADDI, 3'd0, 0, 0, 1, 1), ve(3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 0, 3'd0, 0, 9));
      push(vi(0, ADDI, 3'd0, 0, 0, 1, 1), ve(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 10));

      // Reset with run and readys high: every request and enable must stay low.
      rst = 1'b1;
      apply(vi(1, ADD, 3'd0, 0, 1, 1, 1));
      @(negedge clk); #1;
      check("reset_state", 64'(actual()), 64'(ve(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 0)));
      @(negedge clk);
      apply(vi(0, ADD, 3'd0, 0, 0, 0, 0));
      rst = 1'b0;

      for (int k = 0; k < vt.size(); k++) begin
         @(negedge clk);
         apply(vt[k].i);
         #1;
         check($sformatf("vec%0d", k), 64'(actual()), 64'(vt[k].e));
      end

      // Reset asserted mid-MEM with dmem_req high.
      @(negedge clk); apply(vi(1, LW, 3'd2, 0, 0, 1, 0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); #1;
      check("mem_wait_req", 64'({state, dmem_req, instret}), 64'({3'd3, 1'b1, 32'd10}));
      rst = 1'b1;
      #1;
      check("rst_mid_mem", 64'({state, dmem_req, imem_req, instret}), 64'({3'd0, 1'b0, 1'b0, 32'd0}));
      @(negedge clk);
      rst = 1'b0;

      // Illegal opcode traps after DECODE and stays there.
      apply(vi(1, 7'b0000000, 3'd0, 0, 0, 1, 1));
      #1;
      check("illegal_fetch", 64'({state, imem_req}), 64'({3'd0, 1'b1}));
      @(negedge clk); #1;
      check("illegal_decode", 64'(state), 64'(3'd1));
      @(negedge clk); #1;
      check("illegal_trap", 64'({state, trap, trap_cause}), 64'({3'd5, 1'b1, 2'd1}));
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (state !== 3'd5 || trap !== 1'b1 || imem_req || dmem_req || ir_we ||
             pc_we || reg_we || instret !== 32'd0)
            bad++;
      end
      check("trap_sticky_quiet", 64'(bad), 64'(0));
      rst = 1'b1;
      #1;
      check("trap_cleared_by_rst", 64'({state, trap, trap_cause}), 64'({3'd0, 1'b0, 2'd0}));
      @(negedge clk);
      rst = 1'b0;

      // Fetch with imem_ready held low.
      apply(vi(1, ADD, 3'd0, 0, 0, 0, 1));
`ifdef MC_WDT_EN
      n = 0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (state === 3'd5) break;
         if (imem_req) n++;
         @(negedge clk);
      end
      check("wdt_request_cycles", 64'(n), 64'(16));
      check("wdt_trap", 64'({state, trap, trap_cause, imem_req}), 64'({3'd5, 1'b1, 2'd2, 1'b0}));
`else
      n = 0;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (state === 3'd0 && imem_req === 1'b1 && trap === 1'b0 && trap_cause === 2'd0) n++;
         else bad++;
         @(negedge clk);
      end
      check("fetch_persists", 64'(n), 64'(100));
      check("no_wdt_trap", 64'({state, trap, trap_cause}), 64'({3'd0, 1'b0, 2'd0}));
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
